// File: rtl/boreal_sram_arbiter.sv
// Two-master round-robin arbiter in front of a single-port, 1-cycle-latency SRAM tile.
// One transaction in flight; out-of-range or misaligned addresses are answered locally.

module boreal_sram_arbiter_rsp_port #(
  parameter logic ID = 1'b0
) (
  input  logic        resp_act_i,
  input  logic        owner_i,
  input  logic [31:0] rdata_i,
  input  logic        err_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);
  assign valid_o = resp_act_i && (owner_i == ID);
  assign rdata_o = valid_o ? rdata_i : '0;
  assign err_o   = valid_o & err_i;
endmodule

module boreal_sram_arbiter #(
  parameter int unsigned WORDS     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req_valid,
  output logic        m0_req_ready,
  input  logic        m0_req_we,
  input  logic [31:0] m0_req_addr,
  input  logic [31:0] m0_req_wdata,
  input  logic [3:0]  m0_req_wstrb,
  output logic        m0_resp_valid,
  input  logic        m0_resp_ready,
  output logic [31:0] m0_resp_rdata,
  output logic        m0_resp_err,
  input  logic        m1_req_valid,
  output logic        m1_req_ready,
  input  logic        m1_req_we,
  input  logic [31:0] m1_req_addr,
  input  logic [31:0] m1_req_wdata,
  input  logic [3:0]  m1_req_wstrb,
  output logic        m1_resp_valid,
  input  logic        m1_resp_ready,
  output logic [31:0] m1_resp_rdata,
  output logic        m1_resp_err,
  output logic        sram_req_valid,
  output logic        sram_req_we,
  output logic [31:0] sram_req_addr,
  output logic [31:0] sram_req_wdata,
  output logic [3:0]  sram_req_wstrb,
  input  logic        sram_resp_valid,
  input  logic [31:0] sram_resp_rdata,
  input  logic        sram_resp_err
);
  localparam int          NUM_M = 2;
  localparam logic [31:0] SPAN  = 32'(WORDS * 4);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] off;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic [NUM_M-1:0]       req_valid, req_we, resp_ready, gnt;
  logic [NUM_M-1:0][31:0] req_addr, req_wdata;
  logic [NUM_M-1:0][3:0]  req_wstrb;
  logic [NUM_M-1:0]       rsp_valid, rsp_err;
  logic [NUM_M-1:0][31:0] rsp_rdata;

  assign req_valid  = {m1_req_valid, m0_req_valid};
  assign req_we     = {m1_req_we, m0_req_we};
  assign req_addr   = {m1_req_addr, m0_req_addr};
  assign req_wdata  = {m1_req_wdata, m0_req_wdata};
  assign req_wstrb  = {m1_req_wstrb, m0_req_wstrb};
  assign resp_ready = {m1_resp_ready, m0_resp_ready};

  state_t      state_q, state_d;
  logic        rr_q, rr_d;
  logic        owner_q, owner_d;
  req_t        req_q, req_d;
  rsp_t        rsp_q, rsp_d;

  logic        idle, sel, legal;
  logic [31:0] sel_addr, off;

  // rr_q names the master that wins a tie.
  assign idle   = (state_q == IDLE);
  assign gnt[0] = idle && req_valid[0] && (!req_valid[1] || !rr_q);
  assign gnt[1] = idle && req_valid[1] && (!req_valid[0] ||  rr_q);
  assign sel    = gnt[1];

  // Addresses below BASE_ADDR wrap to a large offset and fail the range test.
  assign sel_addr = req_addr[sel];
  assign off      = sel_addr - BASE_ADDR;
  assign legal    = (sel_addr[1:0] == 2'b00) && (off < SPAN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
      req_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      req_q   <= req_d;
      rsp_q   <= rsp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    req_d   = req_q;
    rsp_d   = rsp_q;
    unique case (state_q)
      IDLE: begin
        if (|gnt) begin
          owner_d = sel;
          rr_d    = ~sel;
          req_d   = '{we: req_we[sel], off: off, wdata: req_wdata[sel], wstrb: req_wstrb[sel]};
          if (legal) begin
            state_d = ISSUE;
            rsp_d   = '0;
          end else begin
            state_d = RESP;
            rsp_d   = '{rdata: 32'h0, err: 1'b1};
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (sram_resp_valid) begin
          rsp_d   = '{rdata: sram_resp_rdata, err: sram_resp_err};
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Tile fields are gated so the bus is quiet outside the issue cycle.
  assign sram_req_valid = (state_q == ISSUE);
  assign sram_req_we    = sram_req_valid & req_q.we;
  assign sram_req_addr  = sram_req_valid ? req_q.off   : '0;
  assign sram_req_wdata = sram_req_valid ? req_q.wdata : '0;
  assign sram_req_wstrb = sram_req_valid ? req_q.wstrb : '0;

  assign m0_req_ready = gnt[0];
  assign m1_req_ready = gnt[1];

  for (genvar m = 0; m < NUM_M; m++) begin : g_rsp
    boreal_sram_arbiter_rsp_port #(.ID(1'(m))) u_rsp (
      .resp_act_i (state_q == RESP),
      .owner_i    (owner_q),
      .rdata_i    (rsp_q.rdata),
      .err_i      (rsp_q.err),
      .valid_o    (rsp_valid[m]),
      .rdata_o    (rsp_rdata[m]),
      .err_o      (rsp_err[m])
    );
  end

  assign m0_resp_valid = rsp_valid[0];
  assign m0_resp_rdata = rsp_rdata[0];
  assign m0_resp_err   = rsp_err[0];
  assign m1_resp_valid = rsp_valid[1];
  assign m1_resp_rdata = rsp_rdata[1];
  assign m1_resp_err   = rsp_err[1];

endmodule

// File: tb/tb_boreal_sram_arbiter.sv
// Directed bench for boreal_sram_arbiter: behavioural tile model, expected-response
// queue filled by the stimulus, and a negedge monitor that checks every handshake.

module tb_boreal_sram_arbiter;
  localparam logic [31:0] BASE = 32'h0001_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        mv[2], mwe[2], mrdy[2], rv[2], rr_i[2], rerr[2];
  logic [31:0] maddr[2], mwd[2], rd[2];
  logic [3:0]  mws[2];

  logic        sram_req_valid, sram_req_we, sram_resp_valid, sram_resp_err;
  logic [31:0] sram_req_addr, sram_req_wdata, sram_resp_rdata;
  logic [3:0]  sram_req_wstrb;

  boreal_sram_arbiter #(.WORDS(1024), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(mv[0]), .m0_req_ready(mrdy[0]), .m0_req_we(mwe[0]),
    .m0_req_addr(maddr[0]), .m0_req_wdata(mwd[0]), .m0_req_wstrb(mws[0]),
    .m0_resp_valid(rv[0]), .m0_resp_ready(rr_i[0]), .m0_resp_rdata(rd[0]), .m0_resp_err(rerr[0]),
    .m1_req_valid(mv[1]), .m1_req_ready(mrdy[1]), .m1_req_we(mwe[1]),
    .m1_req_addr(maddr[1]), .m1_req_wdata(mwd[1]), .m1_req_wstrb(mws[1]),
    .m1_resp_valid(rv[1]), .m1_resp_ready(rr_i[1]), .m1_resp_rdata(rd[1]), .m1_resp_err(rerr[1]),
    .sram_req_valid(sram_req_valid), .sram_req_we(sram_req_we), .sram_req_addr(sram_req_addr),
    .sram_req_wdata(sram_req_wdata), .sram_req_wstrb(sram_req_wstrb),
    .sram_resp_valid(sram_resp_valid), .sram_resp_rdata(sram_resp_rdata), .sram_resp_err(sram_resp_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Tile model: configurable latency, read-before-write, byte strobes.
  logic [31:0] mem [0:1023];
  logic        t_pend = 1'b0;
  int          t_cnt = 0;
  logic [31:0] t_rd = '0;
  logic        t_er = 1'b0;
  int          tile_lat = 1;
  logic        tile_err = 1'b0;
  int          sreq_cnt = 0;
  logic [31:0] last_addr = '0;

  initial for (int i = 0; i < 1024; i++) mem[i] = '0;

  always @(posedge clk) begin
    if (t_pend) begin
      if (t_cnt == 0) t_pend <= 1'b0;
      else t_cnt <= t_cnt - 1;
    end
    if (sram_req_valid) begin
      t_pend    <= 1'b1;
      t_cnt     <= tile_lat - 1;
      t_rd      <= mem[sram_req_addr[11:2]];
      t_er      <= tile_err;
      sreq_cnt  <= sreq_cnt + 1;
      last_addr <= sram_req_addr;
      if (sram_req_we)
        for (int b = 0; b < 4; b++)
          if (sram_req_wstrb[b]) mem[sram_req_addr[11:2]][8*b +: 8] <= sram_req_wdata[8*b +: 8];
    end
  end
  assign sram_resp_valid = t_pend && (t_cnt == 0);
  assign sram_resp_rdata = t_rd;
  assign sram_resp_err   = t_er;

  typedef struct {
    logic        mst;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  logic        pv[2], pr[2];
  logic [31:0] prd[2];
  logic        prev_sreq;
  initial begin
    pv = '{1'b0, 1'b0};
    pr = '{1'b0, 1'b0};
    prd = '{32'h0, 32'h0};
    prev_sreq = 1'b0;
  end

  // Monitor: response ordering/content, hold under back-pressure, one-cycle issue pulse.
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (pv[m] && !pr[m]) begin
        chk($sformatf("hold_valid_m%0d", m), 32'(rv[m]), 32'h1);
        chk($sformatf("hold_rdata_m%0d", m), rd[m], prd[m]);
      end
      if (rv[m] && rr_i[m]) begin
        if (sb.size() == 0) fail_now($sformatf("unexpected_resp_m%0d", m));
        else begin
          chk("resp_owner", 32'(m), 32'(sb[0].mst));
          chk("resp_rdata", rd[m], sb[0].rdata);
          chk("resp_err", 32'(rerr[m]), 32'(sb[0].err));
          void'(sb.pop_front());
        end
      end
      pv[m]  <= rv[m];
      pr[m]  <= rr_i[m];
      prd[m] <= rd[m];
    end
    if (rv[0] || rv[1]) chk("one_resp_port", 32'(rv[0] & rv[1]), 32'h0);
    if (sram_req_valid) chk("sreq_pulse", 32'(prev_sreq), 32'h0);
    prev_sreq <= sram_req_valid;
  end

  task automatic outs_zero(input string nm);
    chk(nm, 32'(|{mrdy[0], mrdy[1], rv[0], rv[1], rd[0], rd[1], rerr[0], rerr[1], sram_req_valid,
                  sram_req_we, sram_req_addr, sram_req_wdata, sram_req_wstrb}), 32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    outs_zero("reset_outputs");
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic set_req(input int m, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] ws);
    mv[m] = 1'b1; mwe[m] = we; maddr[m] = addr; mwd[m] = wd; mws[m] = ws;
  endtask

  task automatic do_req(input int m, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, input logic [31:0] erd, input logic eerr, input int lat);
    int k;
    int t;
    @(posedge clk); #1;
    set_req(m, we, addr, wd, ws);
    k = 0;
    @(negedge clk);
    while (!mrdy[m] && k < 30) begin @(negedge clk); k++; end
    if (!mrdy[m]) begin
      fail_now("accept_timeout");
      mv[m] = 1'b0;
      return;
    end
    t = cyc;
    sb.push_back('{mst: m[0], rdata: erd, err: eerr});
    @(posedge clk); #1 mv[m] = 1'b0;
    k = 0;
    @(negedge clk);
    while (!rv[m] && k < 30) begin @(negedge clk); k++; end
    chk("resp_latency", 32'(cyc - t), 32'(lat));
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 60) begin @(negedge clk); k++; end
    chk("scoreboard_drain", 32'(sb.size()), 32'h0);
  endtask

  initial begin
    int s0, k, t, w;
    int got[2];
    for (int m = 0; m < 2; m++) begin
      mv[m] = 1'b0; mwe[m] = 1'b0; maddr[m] = '0; mwd[m] = '0; mws[m] = '0; rr_i[m] = 1'b1;
    end

    // Reset, write then read back.
    do_reset();
    do_req(0, 1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 3);
    chk("sram_addr_offset", last_addr, 32'h10);
    do_req(0, 1'b0, BASE + 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 3);

    // Fairness with both masters continuously valid.
    do_reset();
    @(posedge clk); #1;
    set_req(0, 1'b0, BASE + 32'h10, 32'h0, 4'h0);
    set_req(1, 1'b0, BASE + 32'h20, 32'h0, 4'h0);
    got[0] = 0; got[1] = 0;
    for (int g = 0; g < 4; g++) begin
      k = 0;
      @(negedge clk);
      while (!(mrdy[0] || mrdy[1]) && k < 20) begin @(negedge clk); k++; end
      if (!(mrdy[0] || mrdy[1])) begin fail_now("rr_grant_timeout"); break; end
      chk("rr_single_ready", 32'(mrdy[0] & mrdy[1]), 32'h0);
      w = mrdy[1] ? 1 : 0;
      chk("rr_grant_order", 32'(w), 32'(g % 2));
      sb.push_back('{mst: w[0], rdata: (w == 0) ? 32'hDEADBEEF : 32'h0, err: 1'b0});
      got[w]++;
      @(posedge clk); #1;
      if (got[w] == 2) mv[w] = 1'b0;
    end
    mv[0] = 1'b0; mv[1] = 1'b0;
    drain();

    // Address checks: out of range, misaligned, below base, last legal word.
    s0 = sreq_cnt;
    do_req(0, 1'b0, BASE + 32'h1000, 32'h0, 4'h0, 32'h0, 1'b1, 1);
    do_req(1, 1'b0, BASE + 32'h6, 32'h0, 4'h0, 32'h0, 1'b1, 1);
    do_req(0, 1'b1, BASE - 32'h4, 32'h55, 4'hF, 32'h0, 1'b1, 1);
    chk("illegal_no_tile_access", 32'(sreq_cnt - s0), 32'h0);
    do_req(1, 1'b0, BASE + 32'hFFC, 32'h0, 4'h0, 32'h0, 1'b0, 3);
    chk("sram_addr_last_word", last_addr, 32'hFFC);

    // Partial write, tile error forwarding, zero-strobe write.
    do_req(1, 1'b1, BASE + 32'h40, 32'h11223344, 4'hF, 32'h0, 1'b0, 3);
    do_req(1, 1'b1, BASE + 32'h40, 32'hAABBCCDD, 4'b0101, 32'h11223344, 1'b0, 3);
    do_req(1, 1'b0, BASE + 32'h40, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 3);
    tile_err = 1'b1;
    do_req(0, 1'b0, BASE + 32'h40, 32'h0, 4'h0, 32'h11BB33DD, 1'b1, 3);
    tile_err = 1'b0;
    do_req(0, 1'b1, BASE + 32'h40, 32'hFFFFFFFF, 4'h0, 32'h11BB33DD, 1'b0, 3);
    do_req(0, 1'b0, BASE + 32'h40, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 3);

    // Back-pressure on m1 while m0 waits.
    @(posedge clk); #1;
    rr_i[1] = 1'b0;
    set_req(1, 1'b0, BASE + 32'h40, 32'h0, 4'h0);
    k = 0;
    @(negedge clk);
    while (!mrdy[1] && k < 20) begin @(negedge clk); k++; end
    if (!mrdy[1]) fail_now("bp_accept_timeout");
    t = cyc;
    sb.push_back('{mst: 1'b1, rdata: 32'h11BB33DD, err: 1'b0});
    @(posedge clk); #1;
    mv[1] = 1'b0;
    set_req(0, 1'b0, BASE + 32'h10, 32'h0, 4'h0);
    k = 0;
    @(negedge clk);
    while (!rv[1] && k < 20) begin chk("bp_m0_blocked", 32'(mrdy[0]), 32'h0); @(negedge clk); k++; end
    chk("bp_m1_latency", 32'(cyc - t), 32'h3);
    for (int i = 0; i < 5; i++) begin
      chk("bp_m0_blocked", 32'(mrdy[0]), 32'h0);
      @(posedge clk); #1;
    end
    rr_i[1] = 1'b1;
    @(negedge clk);
    chk("bp_m0_blocked_hs", 32'(mrdy[0]), 32'h0);
    @(negedge clk);
    chk("bp_m0_granted_after_hs", 32'(mrdy[0]), 32'h1);
    t = cyc;
    sb.push_back('{mst: 1'b0, rdata: 32'hDEADBEEF, err: 1'b0});
    @(posedge clk); #1 mv[0] = 1'b0;
    k = 0;
    @(negedge clk);
    while (!rv[0] && k < 20) begin @(negedge clk); k++; end
    chk("bp_m0_latency", 32'(cyc - t), 32'h3);
    drain();

    // Reset during WAIT with a slow tile; late response must be ignored.
    @(posedge clk); #1;
    tile_lat = 3;
    set_req(0, 1'b0, BASE + 32'h10, 32'h0, 4'h0);
    k = 0;
    @(negedge clk);
    while (!mrdy[0] && k < 20) begin @(negedge clk); k++; end
    if (!mrdy[0]) fail_now("rstw_accept_timeout");
    @(posedge clk); #1 mv[0] = 1'b0;
    @(negedge clk);
    chk("rstw_issue", 32'(sram_req_valid), 32'h1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    outs_zero("rstw_outputs_after_reset");
    @(negedge clk);
    outs_zero("rstw_late_resp_ignored");
    @(negedge clk);
    outs_zero("rstw_idle");
    tile_lat = 1;
    @(posedge clk); #1;
    set_req(0, 1'b0, BASE + 32'h10, 32'h0, 4'h0);
    set_req(1, 1'b0, BASE + 32'h20, 32'h0, 4'h0);
    @(negedge clk);
    chk("rstw_first_grant_m0", 32'({mrdy[1], mrdy[0]}), 32'h1);
    if (mrdy[0]) sb.push_back('{mst: 1'b0, rdata: 32'hDEADBEEF, err: 1'b0});
    @(posedge clk); #1 mv[0] = 1'b0;
    k = 0;
    @(negedge clk);
    while (!mrdy[1] && k < 20) begin @(negedge clk); k++; end
    if (!mrdy[1]) fail_now("rstw_m1_accept_timeout");
    else sb.push_back('{mst: 1'b1, rdata: 32'h0, err: 1'b0});
    @(posedge clk); #1 mv[1] = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/boreal_sram_arbiter.md
Name: boreal_sram_arbiter

Overview:
- Two-master request arbiter that sits directly upstream of the single-port SRAM tile and is its only requester.
- Arbitrates round-robin, validates addresses, issues one request at a time on the tile's fixed 1-cycle-latency port, and routes the response back to the granted master.
- Masters use valid/ready on both request and response channels.
- One transaction is in flight at a time.

Parameters:
- WORDS, 1024: tile depth in 32-bit words; must match the tile's WORDS.
- BASE_ADDR, 32'h0000_0000: byte address mapped to tile word 0; must be 4-byte aligned.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mN_req_valid  in  1  request valid from master N (N = 0, 1; every mN_ port exists for both).
- mN_req_ready  out  1  request accepted when valid && ready.
- mN_req_we  in  1  1 = write, 0 = read.
- mN_req_addr  in  32  byte address.
- mN_req_wdata  in  32  write data.
- mN_req_wstrb  in  4  byte enables.
- mN_resp_valid  out  1  response valid to master N.
- mN_resp_ready  in  1  master N accepts the response.
- mN_resp_rdata  out  32  read data (read-before-write value for writes).
- mN_resp_err  out  1  error flag.
- sram_req_valid  out  1  to tile req_valid.
- sram_req_we  out  1  to tile req_we.
- sram_req_addr  out  32  tile-relative byte address.
- sram_req_wdata  out  32  to tile req_wdata.
- sram_req_wstrb  out  4  to tile req_wstrb.
- sram_resp_valid  in  1  from tile.
- sram_resp_rdata  in  32  from tile.
- sram_resp_err  in  1  from tile.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE, rr_ptr=0.
  - All outputs 0: sram_req_*, mN_resp_*, mN_req_ready.
  - Request and response holding registers cleared.
  - Reset mid-transaction abandons it; a tile response arriving after reset is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - mN_req_ready is combinational and asserted only for the winner.
  - Winner: if exactly one master is valid, that master; if both are valid, master rr_ptr.
  - On accept, latch we/addr/wdata/wstrb and owner id, and set rr_ptr = ~owner.
  - Address check: off = addr - BASE_ADDR (32-bit, wrapping). Legal iff addr[1:0]==0 and off < WORDS*4, compared unsigned; an addr below BASE_ADDR wraps high and is illegal.
  - Legal -> ISSUE.
  - Illegal -> RESP with err=1, rdata=0. The tile is never accessed.
- ISSUE (exactly 1 cycle):
  - sram_req_valid=1, with sram_req_addr=off and the other sram_req_* fields from the latched request.
  - Next state WAIT. sram_req_valid is 0 in every other state.
- WAIT:
  - When sram_resp_valid=1, capture rdata and err, then -> RESP.
  - Tile latency is 1, so WAIT lasts 1 cycle; the FSM still waits indefinitely for sram_resp_valid.
  - sram_resp_valid seen in IDLE, ISSUE or RESP is ignored.
- RESP:
  - m{owner}_resp_valid=1 with captured rdata/err held stable; the other master's resp_valid stays 0.
  - On m{owner}_resp_ready=1 -> IDLE, and resp_valid drops next cycle.
  - No request is accepted in ISSUE, WAIT or RESP (all req_ready=0).
- Latency:
  - Legal request accepted at cycle T: sram_req_valid at T+1, tile response at T+2, mN_resp_valid at T+3.
  - Illegal request: mN_resp_valid at T+1.
  - Best-case throughput: one legal transaction per 4 cycles.
- Fairness: with both masters continuously valid, grants alternate 0,1,0,1...; the first grant after reset goes to m0.
- A master deasserting req_valid before acceptance is legal; nothing is latched.
- Tile resp_err is forwarded unchanged.
- wstrb=0 writes are forwarded; the tile performs a read-only access.

Test Plan:
- Reset, then m0 writes addr=BASE+0x10, wdata=32'hDEADBEEF, wstrb=4'hF; then m0 reads 0x10 -> write resp err=0; read resp rdata=32'hDEADBEEF, err=0 at T+3; sram_req_addr=0x10.
- m0 and m1 both hold valid reads for 4 transactions -> grant order m0,m1,m0,m1. Each response appears only on its owner's resp port; sram_req_valid is a 1-cycle pulse per transaction.
- WORDS=1024: read at addr BASE+0x1000 and at BASE+0x6 -> both give resp_valid at T+1 with err=1, rdata=0; sram_req_valid stays 0.
- Partial write: write 32'h11223344 with wstrb=4'hF, then wdata=32'hAABBCCDD with wstrb=4'b0101, then read -> rdata=32'h11BB33DD.
- Back-pressure: m1 holds resp_ready=0 for 5 cycles while m0 is valid -> m1_resp_valid and rdata stay stable; m0_req_ready=0 throughout; m0 is granted the cycle after m1's handshake completes.
- Assert rst during WAIT, then release -> all outputs 0 the next cycle; the late sram_resp_valid is ignored; the next request goes to m0 (rr_ptr=0).
